gate_pulse_scheduler: RTL
=========================

GATE_PULSE_SCHEDULER -- requirements
Module: gate_pulse_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of gate requesters (fixed at 4 for this release).
REQ-002 Parameter HOLDOFF_W, default 8, width of the holdoff counter and cfg_holdoff.
REQ-003 Parameter TIMEOUT, default 4, cycles allowed after en_pulse for gate_set_in to rise.
REQ-004 sys_clk  input  1  system clock; the only clock, all logic on its rising edge.
REQ-005 sys_rst_n  input  1  synchronous, active-low reset.
REQ-006 req  input  N_REQ  level requests; bit i high = requester i wants one gate pulse.
REQ-007 cfg_en  input  N_REQ  per-requester enable; bit i low = req[i] ignored.
REQ-008 cfg_holdoff  input  HOLDOFF_W  idle gap in cycles enforced after each gate ends.
REQ-009 gate_set_in  input  1  gate level returned by the downstream pulse-shaping block.
REQ-010 err_clr  input  1  one-cycle clear of err_timeout.
REQ-011 en_pulse  output  1  one-cycle start strobe to the pulse-shaping block.
REQ-012 grant  output  N_REQ  one-hot owner of the current gate; zero when not owned.
REQ-013 ack  output  N_REQ  one-cycle completion strobe to the granted requester.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 err_timeout  output  1  sticky flag: shaper failed to respond.

Function
REQ-016 Block SHALL implement states IDLE, FIRE, WAIT_HI, WAIT_LO, HOLDOFF; all outputs registered.
REQ-017 IDLE: eligible = req & cfg_en; if nonzero, select by round-robin starting at pointer rr_ptr, go FIRE.
REQ-018 Round-robin: after selecting requester i, rr_ptr SHALL become (i+1) mod N_REQ; rr_ptr resets to 0.
REQ-019 Latency: eligible request sampled in IDLE at edge T -> en_pulse=1 and grant set during cycle T+1.
REQ-020 FIRE: en_pulse high exactly one cycle, then WAIT_HI; grant held from FIRE until leaving WAIT_LO or timeout.
REQ-021 WAIT_HI: on gate_set_in=1 go WAIT_LO; if not high within TIMEOUT cycles of leaving FIRE, set err_timeout, clear grant, no ack, go HOLDOFF.
REQ-022 WAIT_LO: on gate_set_in=0 pulse ack[i] one cycle (same cycle grant clears), go HOLDOFF.
REQ-023 HOLDOFF: count cfg_holdoff cycles (sampled on entry), then IDLE; cfg_holdoff=0 SHALL go to IDLE after one cycle.
REQ-024 Holdoff counter SHALL not wrap; cfg_holdoff=255 gives exactly 255 HOLDOFF cycles.
REQ-025 Requests arriving outside IDLE SHALL not be lost if still asserted on return to IDLE; deasserted requests are forgotten.
REQ-026 req[i] dropping while granted SHALL not abort the gate; ack still issued.
REQ-027 cfg_en[i] cleared while granted SHALL not abort the gate; takes effect at next arbitration.
REQ-028 err_clr and a new timeout in the same cycle: set wins, err_timeout stays 1.
REQ-029 Only one gate SHALL be in flight; en_pulse SHALL never assert outside FIRE.
REQ-030 gate_set_in high while in IDLE or HOLDOFF SHALL be ignored.

Reset
REQ-031 While sys_rst_n=0 at a rising edge: state=IDLE, en_pulse=0, grant=0, ack=0, busy=0, err_timeout=0, rr_ptr=0, holdoff count=0.
REQ-032 Reset asserted mid-gate SHALL abandon the gate with no ack; first arbitration after release starts from requester 0.

Verification
REQ-033 req=4'b0001, cfg_en=4'hF, cfg_holdoff=3, shaper model 6-cycle gate -> en_pulse 1 cycle after sample, grant=0001 until gate falls, ack[0] one cycle, busy low 3+1 cycles after fall.
REQ-034 req=4'b1111 held, holdoff=0 -> grants in order 0001,0010,0100,1000,0001; never two grants at once.
REQ-035 Shaper never raises gate_set_in, TIMEOUT=4 -> err_timeout=1 five cycles after en_pulse, grant=0, no ack; err_clr -> 0 next cycle.
REQ-036 req=4'b0101, cfg_en=4'b0100 -> only requester 2 granted; cfg_en=0 -> no en_pulse ever.
REQ-037 sys_rst_n low during WAIT_LO for 1 cycle -> all outputs 0 next cycle, no ack, next grant to lowest eligible index.
REQ-038 cfg_holdoff=255 -> next en_pulse exactly 255+2 cycles after gate falls with req continuously high.

Source files
------------

// File: rtl/gate_pulse_scheduler.sv
// Gate pulse scheduler: round-robin arbitration between gate requesters, one
// gate in flight at a time. Each grant fires a one-cycle start strobe to the
// downstream pulse shaper, waits for the returned gate to rise and fall, acks
// the owner and then enforces a programmable idle gap before re-arbitrating.
// A shaper that never raises its gate is detected and flagged as a sticky error.
// All outputs are registered; every state element uses a synchronous reset.

module gate_pulse_scheduler #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned HOLDOFF_W = 8,
    parameter int unsigned TIMEOUT   = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     cfg_en,
    input  logic [HOLDOFF_W-1:0] cfg_holdoff,
    input  logic                 gate_set_in,
    input  logic                 err_clr,
    output logic                 en_pulse,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     ack,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFire    = 3'd1;
    localparam logic [2:0] StWaitHi  = 3'd2;
    localparam logic [2:0] StWaitLo  = 3'd3;
    localparam logic [2:0] StHoldoff = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HOLDOFF_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [TO_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 en_pulse_q, en_pulse_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic [N_REQ-1:0]     eligible;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     sel_idx;
    logic                 sel_found;
    logic [N_REQ-1:0]     sel_oh;
    logic [PTR_W-1:0]     ptr_next;

    // Round-robin pick: first eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        eligible  = req & cfg_en;
        cand      = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % int'(N_REQ));
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
        sel_oh          = '0;
        sel_oh[sel_idx] = 1'b1;
        ptr_next        = PTR_W'((int'(sel_idx) + 1) % int'(N_REQ));
    end

    // Next-state and registered-output logic for the gate sequence.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        wait_cnt_d = wait_cnt_q;
        grant_d    = grant_q;
        ack_d      = '0;
        en_pulse_d = 1'b0;
        // A new timeout below overrides a simultaneous clear.
        err_d      = err_q & ~err_clr;

        unique case (state_q)
            StIdle: begin
                // Requests seen here are level-sampled, so anything raised
                // during a previous gate is served if still held now.
                if (sel_found) begin
                    state_d    = StFire;
                    grant_d    = sel_oh;
                    en_pulse_d = 1'b1;
                    rr_ptr_d   = ptr_next;
                end
            end

            StFire: begin
                state_d    = StWaitHi;
                wait_cnt_d = '0;
            end

            StWaitHi: begin
                if (gate_set_in) begin
                    state_d = StWaitLo;
                end else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // Shaper never answered: drop ownership without an ack.
                    state_d    = StHoldoff;
                    grant_d    = '0;
                    err_d      = 1'b1;
                    hold_cnt_d = cfg_holdoff;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end

            StWaitLo: begin
                // The gate completes even if req/cfg_en dropped meanwhile.
                if (!gate_set_in) begin
                    state_d    = StHoldoff;
                    ack_d      = grant_q;
                    grant_d    = '0;
                    hold_cnt_d = cfg_holdoff;
                end
            end

            StHoldoff: begin
                // A loaded value of 0 or 1 both give a single holdoff cycle;
                // counting down stops at 1 so the counter never wraps.
                if (hold_cnt_q <= HOLDOFF_W'(1)) begin
                    state_d    = StIdle;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLDOFF_W'(1);
                end
            end

            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            wait_cnt_q <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            en_pulse_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            en_pulse_q <= en_pulse_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign en_pulse    = en_pulse_q;
    assign grant       = grant_q;
    assign ack         = ack_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule
